// File: rtl/ext_load_sequencer.sv
// ext_load_sequencer: walks up to NUM_REGION programmed regions and copies words
// from a valid/ready host stream into the GB or NIT external write ports, then
// pulses load_done. An abort cancels the walk and pulses aborted instead.
module ext_load_sequencer #(
    parameter int GB_DATA_WIDTH  = 128,
    parameter int NIT_DATA_WIDTH = 330,
    parameter int GB_ADDR_WIDTH  = 17,
    parameter int NIT_ADDR_WIDTH = 12,
    parameter int NUM_REGION     = 4,
    parameter int CNT_WIDTH      = 17
) (
    input  logic                                clk,
    input  logic                                rstn,
    input  logic                                start,
    input  logic                                abort,
    input  logic [$clog2(NUM_REGION+1)-1:0]     cfg_nreg,
    input  logic [NUM_REGION-1:0]               cfg_target,
    input  logic [NUM_REGION*GB_ADDR_WIDTH-1:0] cfg_base,
    input  logic [NUM_REGION*CNT_WIDTH-1:0]     cfg_len,
    input  logic                                s_valid,
    output logic                                s_ready,
    input  logic [NIT_DATA_WIDTH-1:0]           s_data,
    output logic                                gb_we,
    output logic [GB_ADDR_WIDTH-1:0]            gb_waddr,
    output logic [GB_DATA_WIDTH-1:0]            gb_wdata,
    output logic                                nit_we,
    output logic [NIT_ADDR_WIDTH-1:0]           nit_waddr,
    output logic [NIT_DATA_WIDTH-1:0]           nit_wdata,
    output logic                                busy,
    output logic                                load_done,
    output logic                                aborted
);

    localparam int NW    = $clog2(NUM_REGION + 1);
    // Region tables are padded to a power of two so the NW-bit index never
    // runs past the end of the array.
    localparam int NSLOT = 1 << NW;

    typedef enum logic [2:0] {IDLE, SETUP, STREAM, NEXT, DONE} state_t;

    state_t                   state_reg;
    logic [NW-1:0]            nreg_reg;
    logic [NW-1:0]            idx_reg;
    logic [GB_ADDR_WIDTH-1:0] addr_reg;
    logic [CNT_WIDTH-1:0]     remain_reg;
    logic                     cur_nit_reg;

    logic [GB_ADDR_WIDTH-1:0] base_reg   [NSLOT];
    logic [CNT_WIDTH-1:0]     len_reg    [NSLOT];
    logic [NSLOT-1:0]         target_reg;

    logic [GB_ADDR_WIDTH-1:0] cfg_base_slot [NSLOT];
    logic [CNT_WIDTH-1:0]     cfg_len_slot  [NSLOT];
    logic [NSLOT-1:0]         cfg_target_slot;

    logic [NW-1:0] nreg_clamped;
    logic [NW-1:0] idx_inc;
    logic          start_take;
    logic          hs;

    // Unpack the flat configuration buses; padding slots read as empty regions.
    for (genvar gi = 0; gi < NSLOT; gi++) begin : g_slot
        if (gi < NUM_REGION) begin : g_used
            assign cfg_base_slot[gi]   = cfg_base[gi*GB_ADDR_WIDTH +: GB_ADDR_WIDTH];
            assign cfg_len_slot[gi]    = cfg_len[gi*CNT_WIDTH +: CNT_WIDTH];
            assign cfg_target_slot[gi] = cfg_target[gi];
        end else begin : g_pad
            assign cfg_base_slot[gi]   = '0;
            assign cfg_len_slot[gi]    = '0;
            assign cfg_target_slot[gi] = 1'b0;
        end
    end

    assign nreg_clamped = (cfg_nreg > NW'(NUM_REGION)) ? NW'(NUM_REGION) : cfg_nreg;
    assign idx_inc      = idx_reg + NW'(1);
    assign start_take   = start && (state_reg == IDLE);

    // abort blocks a handshake combinationally so a word is never half-taken.
    assign s_ready   = (state_reg == STREAM) && !abort;
    assign hs        = s_ready && s_valid;
    assign busy      = (state_reg != IDLE);
    assign load_done = (state_reg == DONE) && !abort;
    assign aborted   = abort && (state_reg != IDLE);

    // Snapshot the region tables when a load is accepted.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NSLOT; i++) begin
                base_reg[i] <= '0;
                len_reg[i]  <= '0;
            end
            target_reg <= '0;
        end else if (start_take) begin
            for (int i = 0; i < NSLOT; i++) begin
                base_reg[i] <= cfg_base_slot[i];
                len_reg[i]  <= cfg_len_slot[i];
            end
            target_reg <= cfg_target_slot;
        end
    end

    // Sequencer: region walk, address generation and word counting.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg   <= IDLE;
            nreg_reg    <= '0;
            idx_reg     <= '0;
            addr_reg    <= '0;
            remain_reg  <= '0;
            cur_nit_reg <= 1'b0;
        end else if (abort && state_reg != IDLE) begin
            state_reg <= IDLE;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        nreg_reg  <= nreg_clamped;
                        idx_reg   <= '0;
                        state_reg <= (nreg_clamped != '0) ? SETUP : DONE;
                    end
                end
                SETUP: begin
                    addr_reg    <= base_reg[idx_reg];
                    remain_reg  <= len_reg[idx_reg];
                    cur_nit_reg <= target_reg[idx_reg];
                    state_reg   <= (len_reg[idx_reg] == '0) ? NEXT : STREAM;
                end
                STREAM: begin
                    if (hs) begin
                        addr_reg   <= addr_reg + GB_ADDR_WIDTH'(1);
                        remain_reg <= remain_reg - CNT_WIDTH'(1);
                        if (remain_reg == CNT_WIDTH'(1)) begin
                            state_reg <= NEXT;
                        end
                    end
                end
                NEXT: begin
                    idx_reg   <= idx_inc;
                    state_reg <= (idx_inc == nreg_reg) ? DONE : SETUP;
                end
                DONE:    state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Registered write port: one strobe per handshake, on the latched target only.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            gb_we     <= 1'b0;
            gb_waddr  <= '0;
            gb_wdata  <= '0;
            nit_we    <= 1'b0;
            nit_waddr <= '0;
            nit_wdata <= '0;
        end else begin
            gb_we  <= hs && !cur_nit_reg;
            nit_we <= hs && cur_nit_reg;
            if (hs && !cur_nit_reg) begin
                gb_waddr <= addr_reg;
                gb_wdata <= s_data[GB_DATA_WIDTH-1:0];
            end
            if (hs && cur_nit_reg) begin
                nit_waddr <= addr_reg[NIT_ADDR_WIDTH-1:0];
                nit_wdata <= s_data;
            end
        end
    end

endmodule

// File: tb/tb_ext_load_sequencer.sv
// Directed bench for ext_load_sequencer: full preload, backpressure, empty and
// zero-length regions, region-count clamping, wrap-around, abort and reset.
module tb_ext_load_sequencer;

    logic         clk = 1'b0;
    logic         rstn;
    logic         start;
    logic         abort;
    logic [2:0]   cfg_nreg;
    logic [3:0]   cfg_target;
    logic [67:0]  cfg_base;
    logic [67:0]  cfg_len;
    logic         s_valid;
    logic         s_ready;
    logic [329:0] s_data;
    logic         gb_we;
    logic [16:0]  gb_waddr;
    logic [127:0] gb_wdata;
    logic         nit_we;
    logic [11:0]  nit_waddr;
    logic [329:0] nit_wdata;
    logic         busy;
    logic         load_done;
    logic         aborted;

    int n_checks = 0;
    int n_pass   = 0;

    // Scenario configuration (bench model of the region table)
    int m_nreg;
    int m_target [4];
    int m_base   [4];
    int m_len    [4];
    int vmode;        // 0: s_valid always 1, 1: s_valid 1,0,0 repeating
    int abort_after;  // raise abort once this many handshakes happened (-1 = never)
    int scramble;     // change cfg and re-pulse start while busy

    // Observations from the last run
    int r_gb, r_nit, r_err, r_done, r_done_cyc, r_ab, r_ab_cyc;
    int r_first_ready, r_ready_abort, r_busy_after, r_timeout, r_last_hs, r_hs;
    int r_rfirst [4];
    int addr_log [16];

    ext_load_sequencer dut (
        .clk        (clk),
        .rstn       (rstn),
        .start      (start),
        .abort      (abort),
        .cfg_nreg   (cfg_nreg),
        .cfg_target (cfg_target),
        .cfg_base   (cfg_base),
        .cfg_len    (cfg_len),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .gb_we      (gb_we),
        .gb_waddr   (gb_waddr),
        .gb_wdata   (gb_wdata),
        .nit_we     (nit_we),
        .nit_waddr  (nit_waddr),
        .nit_wdata  (nit_wdata),
        .busy       (busy),
        .load_done  (load_done),
        .aborted    (aborted)
    );

    always #5 clk = ~clk;

    function automatic logic [329:0] word_of(input int n);
        logic [329:0] w;
        for (int i = 0; i < 11; i++) w[i*30 +: 30] = 30'(n * 7 + i);
        return w;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_cfg();
        cfg_nreg = 3'(m_nreg);
        for (int i = 0; i < 4; i++) begin
            cfg_target[i]         = (m_target[i] != 0);
            cfg_base[i*17 +: 17]  = 17'(m_base[i]);
            cfg_len[i*17 +: 17]   = 17'(m_len[i]);
        end
    endtask

    // Drives one load cycle by cycle and records what the DUT did against
    // the bench's own region walk. Entered and left at posedge+1.
    task automatic run_load();
        int eff, mr, mk, seq, end_cyc;
        bit pend, pend_nit, hs, ended;
        int pend_addr;
        logic [329:0] pend_data;
        r_gb = 0; r_nit = 0; r_err = 0; r_done = 0; r_done_cyc = -1; r_ab = 0; r_ab_cyc = -1;
        r_first_ready = -1; r_ready_abort = 0; r_busy_after = -1; r_timeout = 0;
        r_last_hs = -1; r_hs = 0;
        for (int i = 0; i < 4; i++) r_rfirst[i] = -1;
        for (int i = 0; i < 16; i++) addr_log[i] = -1;
        eff = (m_nreg > 4) ? 4 : m_nreg;
        mr = 0; mk = 0; seq = 0; end_cyc = 0;
        pend = 0; pend_nit = 0; pend_addr = 0; pend_data = '0; ended = 0;
        while (mr < eff && m_len[mr] == 0) mr++;
        apply_cfg();
        for (int cyc = 0; cyc < 40000; cyc++) begin
            if (gb_we && nit_we) r_err++;
            if (gb_we) begin
                if (r_gb < 16) addr_log[r_gb] = int'(gb_waddr);
                r_gb++;
            end
            if (nit_we) r_nit++;
            if (pend) begin
                if (pend_nit) begin
                    if (!nit_we || nit_waddr !== 12'(pend_addr) || nit_wdata !== pend_data) r_err++;
                end else begin
                    if (!gb_we || gb_waddr !== 17'(pend_addr) || gb_wdata !== pend_data[127:0]) r_err++;
                end
            end else if (gb_we || nit_we) begin
                r_err++;
            end
            if (ended && cyc == end_cyc + 1) r_busy_after = int'(busy);
            if (ended && cyc >= end_cyc + 2) break;
            start = (cyc == 0);
            if (scramble != 0 && cyc == 1) begin
                start      = 1'b1;
                cfg_nreg   = 3'd1;
                cfg_target = ~cfg_target;
                cfg_base   = ~cfg_base;
                cfg_len    = '0;
            end
            s_valid = (vmode == 0) ? 1'b1 : (cyc % 3 == 0);
            abort   = (abort_after >= 0 && r_hs == abort_after && r_ab == 0 && !ended);
            s_data  = word_of(seq);
            #1;
            hs = s_ready && s_valid;
            if (s_ready && abort) r_ready_abort++;
            if (s_ready && r_first_ready < 0) r_first_ready = cyc;
            if (load_done) begin
                r_done++;
                if (!ended) begin ended = 1; end_cyc = cyc; r_done_cyc = cyc; end
            end
            if (aborted) begin
                r_ab++;
                r_ab_cyc = cyc;
                if (!ended) begin ended = 1; end_cyc = cyc; end
            end
            pend = hs;
            if (hs) begin
                r_hs++;
                r_last_hs = cyc;
                if (mr < eff) begin
                    if (mk == 0) r_rfirst[mr] = cyc;
                    pend_nit  = (m_target[mr] != 0);
                    pend_addr = m_base[mr] + mk;
                    pend_data = word_of(seq);
                    mk++;
                    if (mk == m_len[mr]) begin
                        mr++;
                        mk = 0;
                        while (mr < eff && m_len[mr] == 0) mr++;
                    end
                end else begin
                    r_err++;
                end
                seq++;
            end
            @(posedge clk);
            #1;
        end
        if (!ended) r_timeout = 1;
        start = 1'b0; s_valid = 1'b0; abort = 1'b0;
    endtask

    task automatic set_defaults();
        vmode = 0; abort_after = -1; scramble = 0;
        for (int i = 0; i < 4; i++) begin m_target[i] = 0; m_base[i] = 0; m_len[i] = 0; end
    endtask

    task automatic test_reset();
        rstn = 1'b0; start = 1'b0; abort = 1'b0; s_valid = 1'b0; s_data = '0;
        cfg_nreg = '0; cfg_target = '0; cfg_base = '0; cfg_len = '0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (s_ready !== 1'b0) $display("FAIL rst_s_ready: got %b want 0", s_ready); else n_pass++;
        n_checks++; if (gb_we !== 1'b0) $display("FAIL rst_gb_we: got %b want 0", gb_we); else n_pass++;
        n_checks++; if (nit_we !== 1'b0) $display("FAIL rst_nit_we: got %b want 0", nit_we); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else n_pass++;
        n_checks++; if (load_done !== 1'b0) $display("FAIL rst_load_done: got %b want 0", load_done); else n_pass++;
        n_checks++; if (aborted !== 1'b0) $display("FAIL rst_aborted: got %b want 0", aborted); else n_pass++;
        n_checks++; if (gb_waddr !== 17'h0) $display("FAIL rst_gb_waddr: got %h want 0", gb_waddr); else n_pass++;
        n_checks++; if (nit_wdata !== '0) $display("FAIL rst_nit_wdata: got nonzero want 0"); else n_pass++;
        #2 rstn = 1'b1;
        tick();
        $display("test_reset done");
    endtask

    task automatic test_full_preload();
        set_defaults();
        m_nreg = 3;
        m_target[0] = 1; m_base[0] = 0;       m_len[0] = 4096;
        m_target[1] = 0; m_base[1] = 'h00000; m_len[1] = 16384;
        m_target[2] = 0; m_base[2] = 'h08000; m_len[2] = 1024;
        run_load();
        // NIT hs 2..4097, GB hs 4100..20483, GB hs 20486..21509, DONE at 21511
        n_checks++; if (r_timeout !== 0) $display("FAIL pre_timeout: got %0d want 0", r_timeout); else n_pass++;
        n_checks++; if (r_nit !== 4096) $display("FAIL pre_nit_writes: got %0d want 4096", r_nit); else n_pass++;
        n_checks++; if (r_gb !== 17408) $display("FAIL pre_gb_writes: got %0d want 17408", r_gb); else n_pass++;
        n_checks++; if (r_err !== 0) $display("FAIL pre_write_errors: got %0d want 0", r_err); else n_pass++;
        n_checks++; if (r_first_ready !== 2) $display("FAIL pre_first_ready: got %0d want 2", r_first_ready); else n_pass++;
        n_checks++; if (r_rfirst[1] !== 4100) $display("FAIL pre_gap1: got %0d want 4100", r_rfirst[1]); else n_pass++;
        n_checks++; if (r_rfirst[2] !== 20486) $display("FAIL pre_gap2: got %0d want 20486", r_rfirst[2]); else n_pass++;
        n_checks++; if (r_done !== 1) $display("FAIL pre_done_count: got %0d want 1", r_done); else n_pass++;
        n_checks++; if (r_done_cyc !== 21511) $display("FAIL pre_done_cycle: got %0d want 21511", r_done_cyc); else n_pass++;
        n_checks++; if (r_busy_after !== 0) $display("FAIL pre_busy_after: got %0d want 0", r_busy_after); else n_pass++;
        $display("test_full_preload: nit=%0d gb=%0d done_cyc=%0d", r_nit, r_gb, r_done_cyc);
    endtask

    task automatic test_backpressure();
        set_defaults();
        vmode = 1; scramble = 1;
        m_nreg = 1; m_target[0] = 0; m_base[0] = 'h100; m_len[0] = 8;
        run_load();
        // handshakes on cycles 3,6,...,24; DONE at 26
        n_checks++; if (r_gb !== 8) $display("FAIL bp_gb_writes: got %0d want 8", r_gb); else n_pass++;
        n_checks++; if (r_nit !== 0) $display("FAIL bp_nit_writes: got %0d want 0", r_nit); else n_pass++;
        n_checks++; if (r_err !== 0) $display("FAIL bp_write_errors: got %0d want 0", r_err); else n_pass++;
        n_checks++; if (addr_log[7] !== 'h107) $display("FAIL bp_last_addr: got %h want 107", addr_log[7]); else n_pass++;
        n_checks++; if (r_done_cyc !== 26) $display("FAIL bp_done_cycle: got %0d want 26", r_done_cyc); else n_pass++;
        $display("test_backpressure: gb=%0d done_cyc=%0d", r_gb, r_done_cyc);
    endtask

    task automatic test_zero_len();
        set_defaults();
        m_nreg = 3;
        m_target[0] = 0; m_base[0] = 'h50;  m_len[0] = 0;
        m_target[1] = 1; m_base[1] = 'h123; m_len[1] = 3;
        m_target[2] = 0; m_base[2] = 'h60;  m_len[2] = 0;
        run_load();
        // SETUP1 NEXT2 SETUP3 STREAM4-6 NEXT7 SETUP8 NEXT9 DONE10
        n_checks++; if (r_nit !== 3) $display("FAIL zl_nit_writes: got %0d want 3", r_nit); else n_pass++;
        n_checks++; if (r_gb !== 0) $display("FAIL zl_gb_writes: got %0d want 0", r_gb); else n_pass++;
        n_checks++; if (r_err !== 0) $display("FAIL zl_write_errors: got %0d want 0", r_err); else n_pass++;
        n_checks++; if (r_first_ready !== 4) $display("FAIL zl_first_ready: got %0d want 4", r_first_ready); else n_pass++;
        n_checks++; if (r_done_cyc !== 10) $display("FAIL zl_done_cycle: got %0d want 10", r_done_cyc); else n_pass++;
        $display("test_zero_len: nit=%0d done_cyc=%0d", r_nit, r_done_cyc);
    endtask

    task automatic test_empty();
        set_defaults();
        m_nreg = 0; m_len[0] = 5;
        run_load();
        // IDLE goes straight to DONE in the cycle after start
        n_checks++; if (r_done_cyc !== 1) $display("FAIL empty_done_cycle: got %0d want 1", r_done_cyc); else n_pass++;
        n_checks++; if (r_gb + r_nit !== 0) $display("FAIL empty_writes: got %0d want 0", r_gb + r_nit); else n_pass++;
        n_checks++; if (r_first_ready !== -1) $display("FAIL empty_ready_seen: got %0d want -1", r_first_ready); else n_pass++;
        n_checks++; if (r_hs !== 0) $display("FAIL empty_handshakes: got %0d want 0", r_hs); else n_pass++;
        $display("test_empty: done_cyc=%0d", r_done_cyc);
    endtask

    task automatic test_nreg_clamp();
        set_defaults();
        m_nreg = 7;
        for (int i = 0; i < 4; i++) begin m_target[i] = i % 2; m_base[i] = 'h40 * i; m_len[i] = 1; end
        run_load();
        // four single-word regions, 3 cycles each after the start cycle, DONE at 13
        n_checks++; if (r_gb + r_nit !== 4) $display("FAIL clamp_writes: got %0d want 4", r_gb + r_nit); else n_pass++;
        n_checks++; if (r_err !== 0) $display("FAIL clamp_write_errors: got %0d want 0", r_err); else n_pass++;
        n_checks++; if (r_done_cyc !== 13) $display("FAIL clamp_done_cycle: got %0d want 13", r_done_cyc); else n_pass++;
        $display("test_nreg_clamp: writes=%0d done_cyc=%0d", r_gb + r_nit, r_done_cyc);
    endtask

    task automatic test_wrap();
        set_defaults();
        m_nreg = 1; m_target[0] = 0; m_base[0] = 'h1FFFE; m_len[0] = 4;
        run_load();
        n_checks++; if (addr_log[0] !== 'h1FFFE) $display("FAIL wrap_addr0: got %h want 1fffe", addr_log[0]); else n_pass++;
        n_checks++; if (addr_log[1] !== 'h1FFFF) $display("FAIL wrap_addr1: got %h want 1ffff", addr_log[1]); else n_pass++;
        n_checks++; if (addr_log[2] !== 'h00000) $display("FAIL wrap_addr2: got %h want 0", addr_log[2]); else n_pass++;
        n_checks++; if (addr_log[3] !== 'h00001) $display("FAIL wrap_addr3: got %h want 1", addr_log[3]); else n_pass++;
        n_checks++; if (r_err !== 0) $display("FAIL wrap_write_errors: got %0d want 0", r_err); else n_pass++;
        $display("test_wrap: gb=%0d", r_gb);
    endtask

    task automatic test_abort();
        set_defaults();
        abort_after = 5;
        m_nreg = 1; m_target[0] = 0; m_base[0] = 'h200; m_len[0] = 10;
        run_load();
        // handshakes 2..6, abort (blocking a handshake) at cycle 7
        n_checks++; if (r_ab !== 1) $display("FAIL ab_pulse_count: got %0d want 1", r_ab); else n_pass++;
        n_checks++; if (r_ab_cyc !== 7) $display("FAIL ab_cycle: got %0d want 7", r_ab_cyc); else n_pass++;
        n_checks++; if (r_done !== 0) $display("FAIL ab_load_done: got %0d want 0", r_done); else n_pass++;
        n_checks++; if (r_gb !== 5) $display("FAIL ab_gb_writes: got %0d want 5", r_gb); else n_pass++;
        n_checks++; if (r_hs !== 5) $display("FAIL ab_handshakes: got %0d want 5", r_hs); else n_pass++;
        n_checks++; if (r_ready_abort !== 0) $display("FAIL ab_ready_with_abort: got %0d want 0", r_ready_abort); else n_pass++;
        n_checks++; if (r_busy_after !== 0) $display("FAIL ab_busy_after: got %0d want 0", r_busy_after); else n_pass++;
        $display("test_abort: aborted_cyc=%0d gb=%0d", r_ab_cyc, r_gb);
        abort_after = -1; m_base[0] = 'h300; m_len[0] = 3;
        run_load();
        n_checks++; if (r_done !== 1) $display("FAIL ab_restart_done: got %0d want 1", r_done); else n_pass++;
        n_checks++; if (r_gb !== 3) $display("FAIL ab_restart_writes: got %0d want 3", r_gb); else n_pass++;
        n_checks++; if (r_err !== 0) $display("FAIL ab_restart_errors: got %0d want 0", r_err); else n_pass++;
        $display("test_abort restart: gb=%0d done=%0d", r_gb, r_done);
    endtask

    task automatic test_reset_mid_stream();
        int stray;
        set_defaults();
        m_nreg = 1; m_target[0] = 0; m_base[0] = 'h400; m_len[0] = 20;
        apply_cfg();
        start = 1'b1; s_valid = 1'b1; s_data = word_of(99);
        tick();
        start = 1'b0;
        repeat (4) tick();
        // handshakes began in cycle 2, so a write strobe is up now
        n_checks++; if (gb_we !== 1'b1) $display("FAIL rms_pre_we: got %b want 1", gb_we); else n_pass++;
        #1 rstn = 1'b0;
        #1;
        n_checks++; if (gb_we !== 1'b0) $display("FAIL rms_gb_we: got %b want 0", gb_we); else n_pass++;
        n_checks++; if (s_ready !== 1'b0) $display("FAIL rms_s_ready: got %b want 0", s_ready); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL rms_busy: got %b want 0", busy); else n_pass++;
        n_checks++; if (gb_waddr !== 17'h0) $display("FAIL rms_gb_waddr: got %h want 0", gb_waddr); else n_pass++;
        n_checks++; if (gb_wdata !== 128'h0) $display("FAIL rms_gb_wdata: got nonzero want 0"); else n_pass++;
        stray = 0;
        repeat (2) begin tick(); if (gb_we || nit_we) stray++; end
        #1 rstn = 1'b1;
        repeat (3) begin tick(); if (gb_we || nit_we || busy) stray++; end
        n_checks++; if (stray !== 0) $display("FAIL rms_stray_activity: got %0d want 0", stray); else n_pass++;
        s_valid = 1'b0;
        $display("test_reset_mid_stream: stray=%0d", stray);
    endtask

    initial begin
        test_reset();
        test_full_preload();
        test_backpressure();
        test_zero_len();
        test_empty();
        test_nreg_clamp();
        test_wrap();
        test_abort();
        test_reset_mid_stream();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
